// File: rtl/regfile_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// regfile_pkg : shared constants and types for the register-file writeback path
// Rev 1.0
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// wb_fifo : writeback request FIFO exposing every entry in age order
// Rev 1.0
// -----------------------------------------------------------------------------
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  logic [ADDR_W-1:0]             i_pushAddr,
  input  logic [DATA_W-1:0]             i_pushData,
  input  logic                          i_pop,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [DEPTH-1:0][ADDR_W-1:0]  o_ageAddr,
  output logic [DEPTH-1:0][DATA_W-1:0]  o_ageData,
  output logic [DEPTH-1:0]              o_ageValid
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [c_PTR_W-1:0]           r_rdPtr;
  logic [c_PTR_W-1:0]           r_wrPtr;
  logic [c_CNT_W-1:0]           r_count;

  // Storage carries no reset; validity is defined purely by the count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_wrPtr] <= i_pushAddr;
      r_data[r_wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + c_PTR_W'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(i_push) - c_CNT_W'(i_pop);
    end
  end

  assign o_count = r_count;

  // Slot i of the age view is the i-th oldest entry; pointers wrap mod DEPTH.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_age
      logic [c_PTR_W-1:0] w_idx;
      assign w_idx         = r_rdPtr + c_PTR_W'(i);
      assign o_ageAddr[i]  = r_addr[w_idx];
      assign o_ageData[i]  = r_data[w_idx];
      assign o_ageValid[i] = (c_CNT_W'(i) < r_count);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// regfile_writeback_ctrl : buffered RegisterFile write initiator with forwarding
// Rev 1.0
// -----------------------------------------------------------------------------
module regfile_writeback_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic [ADDR_W-1:0]      fwd_addr1,
  input  logic [ADDR_W-1:0]      fwd_addr2,
  output logic                   fwd_hit1,
  output logic [DATA_W-1:0]      fwd_data1,
  output logic                   fwd_hit2,
  output logic [DATA_W-1:0]      fwd_data2,
  output logic                   init_done,
  output logic [$clog2(DEPTH):0] pending_cnt
);

  import regfile_pkg::*;

  localparam int                 c_CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  c_LAST_REG = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0]  c_ZERO     = ADDR_W'(ZERO_REG);

  wb_state_t           r_state;
  logic [ADDR_W-1:0]   r_initPtr;
  logic                r_rfWe;
  logic [ADDR_W-1:0]   r_rfWaddr;
  logic [DATA_W-1:0]   r_rfWdata;
  logic                r_initDone;

  logic [c_CNT_W-1:0]             w_count;
  logic [DEPTH-1:0][ADDR_W-1:0]   w_ageAddr;
  logic [DEPTH-1:0][DATA_W-1:0]   w_ageData;
  logic [DEPTH-1:0]               w_ageValid;
  logic                           w_push;
  logic                           w_pop;

  // No fall-through: a full buffer refuses even on an edge that also pops.
  assign wb_ready = (r_state == RUN) && (w_count < c_DEPTH);
  // Writes to the hardwired zero register complete the handshake but vanish.
  assign w_push   = wb_valid && wb_ready && (wb_addr != c_ZERO);
  assign w_pop    = (r_state == RUN) && (w_count != '0);

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushAddr (wb_addr),
    .i_pushData (wb_data),
    .i_pop      (w_pop),
    .o_count    (w_count),
    .o_ageAddr  (w_ageAddr),
    .o_ageData  (w_ageData),
    .o_ageValid (w_ageValid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_initPtr  <= ADDR_W'(1);
      r_rfWe     <= 1'b0;
      r_rfWaddr  <= '0;
      r_rfWdata  <= '0;
      r_initDone <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_rfWe    <= 1'b1;
          r_rfWaddr <= r_initPtr;
          r_rfWdata <= '0;
          r_initPtr <= r_initPtr + ADDR_W'(1);
          if (r_initPtr == c_LAST_REG) begin
            r_state    <= RUN;
            r_initDone <= 1'b1;
          end
        end
        RUN: begin
          r_rfWe <= w_pop;
          if (w_pop) begin
            r_rfWaddr <= w_ageAddr[0];
            r_rfWdata <= w_ageData[0];
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign rf_we       = r_rfWe;
  assign rf_waddr    = r_rfWaddr;
  assign rf_wdata    = r_rfWdata;
  assign init_done   = r_initDone;
  assign pending_cnt = w_count;

  // Oldest candidate first so that each newer match overrides: rf_* output,
  // then buffer head through tail.
  generate
    for (genvar p = 0; p < 2; p++) begin : g_fwd
      logic [ADDR_W-1:0] w_addr;
      logic              w_hit;
      logic [DATA_W-1:0] w_data;

      assign w_addr = (p == 0) ? fwd_addr1 : fwd_addr2;

      always_comb begin
        w_hit  = 1'b0;
        w_data = '0;
        if (r_rfWe && (r_rfWaddr == w_addr)) begin
          w_hit  = 1'b1;
          w_data = r_rfWdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (w_ageValid[i] && (w_ageAddr[i] == w_addr)) begin
            w_hit  = 1'b1;
            w_data = w_ageData[i];
          end
        end
        if ((r_state != RUN) || (w_addr == c_ZERO)) begin
          w_hit  = 1'b0;
          w_data = '0;
        end
      end
    end
  endgenerate

  assign fwd_hit1  = g_fwd[0].w_hit;
  assign fwd_data1 = g_fwd[0].w_data;
  assign fwd_hit2  = g_fwd[1].w_hit;
  assign fwd_data2 = g_fwd[1].w_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_regfile_writeback_ctrl : randomized bench against a queue-based model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_regfile_writeback_ctrl;

  import regfile_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = ADDR_W;
  localparam int DW    = DATA_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] fwd_addr1;
  logic [AW-1:0] fwd_addr2;
  logic          fwd_hit1;
  logic [DW-1:0] fwd_data1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data2;
  logic          init_done;
  logic [CW-1:0] pending_cnt;

  always #5 clk = ~clk;

  regfile_writeback_ctrl #(
    .DEPTH  (DEPTH),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_addr1   (fwd_addr1),
    .fwd_addr2   (fwd_addr2),
    .fwd_hit1    (fwd_hit1),
    .fwd_data1   (fwd_data1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data2   (fwd_data2),
    .init_done   (init_done),
    .pending_cnt (pending_cnt)
  );

  // RegisterFile stand-in: no reset, powers up with garbage.
  logic [DW-1:0] rfMem [NUM_REGS];
  bit            rfSeeded;
  always @(posedge clk) begin
    if (!rfSeeded) begin
      for (int i = 0; i < NUM_REGS; i++) rfMem[i] <= $urandom;
      rfSeeded <= 1'b1;
    end
    if (rf_we) rfMem[rf_waddr] <= rf_wdata;
  end

  // Reference model: a queue of pending writes, the value on the write port,
  // and the register contents those writes produce.
  wb_entry_t     mQ[$];
  bit            mRfWe;
  logic [AW-1:0] mRfAddr;
  logic [DW-1:0] mRfData;
  bit            mDone;
  int            mNext;
  logic [DW-1:0] mMem [NUM_REGS];

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mRfWe   = 1'b0;
    mRfAddr = '0;
    mRfData = '0;
    mDone   = 1'b0;
    mNext   = 1;
  endtask

  function automatic logic [DW:0] mFwd(input logic [AW-1:0] a);
    if (!mDone || a == '0) return '0;
    for (int i = mQ.size() - 1; i >= 0; i--)
      if (mQ[i].addr == a) return {1'b1, mQ[i].data};
    if (mRfWe && mRfAddr == a) return {1'b1, mRfData};
    return '0;
  endfunction

  function automatic bit mReady();
    return mDone && (mQ.size() < DEPTH);
  endfunction

  task automatic checkOutputs();
    logic [DW:0] e1;
    logic [DW:0] e2;
    e1 = mFwd(fwd_addr1);
    e2 = mFwd(fwd_addr2);
    checkVal("wb_ready",    64'(wb_ready),    64'(mReady()));
    checkVal("pending_cnt", 64'(pending_cnt), 64'(mQ.size()));
    checkVal("init_done",   64'(init_done),   64'(mDone));
    checkVal("rf_we",       64'(rf_we),       64'(mRfWe));
    checkVal("rf_waddr",    64'(rf_waddr),    64'(mRfAddr));
    checkVal("rf_wdata",    64'(rf_wdata),    64'(mRfData));
    checkVal("fwd_hit1",    64'(fwd_hit1),    64'(e1[DW]));
    checkVal("fwd_data1",   64'(fwd_data1),   64'(e1[DW-1:0]));
    checkVal("fwd_hit2",    64'(fwd_hit2),    64'(e2[DW]));
    checkVal("fwd_data2",   64'(fwd_data2),   64'(e2[DW-1:0]));
  endtask

  // What the coming rising edge does, in terms of the model state before it.
  task automatic modelEdge();
    bit        acc;
    wb_entry_t h;
    acc = wb_valid && mReady();
    if (mRfWe) mMem[mRfAddr] = mRfData;
    if (!mDone) begin
      mRfWe   = 1'b1;
      mRfAddr = AW'(mNext);
      mRfData = '0;
      if (mNext == NUM_REGS - 1) mDone = 1'b1;
      mNext++;
    end else begin
      if (mQ.size() > 0) begin
        h       = mQ.pop_front();
        mRfWe   = 1'b1;
        mRfAddr = h.addr;
        mRfData = h.data;
      end else begin
        mRfWe = 1'b0;
      end
      if (acc && wb_addr != '0) begin
        h.addr = wb_addr;
        h.data = wb_data;
        mQ.push_back(h);
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [AW-1:0] f1, input logic [AW-1:0] f2);
    wb_valid  = v;
    wb_addr   = a;
    wb_data   = d;
    fwd_addr1 = f1;
    fwd_addr2 = f2;
    #1;
    checkOutputs();
    modelEdge();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [AW-1:0] f1, input logic [AW-1:0] f2);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, f1, f2);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int budget;
    rst       = 1'b1;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    fwd_addr1 = '0;
    fwd_addr2 = '0;
    modelReset();
    for (int i = 0; i < NUM_REGS; i++) mMem[i] = '0;

    // Reset state
    @(negedge clk);
    #1;
    checkVal("rst_rf_we",    64'(rf_we),       64'd0);
    checkVal("rst_rf_waddr", 64'(rf_waddr),    64'd0);
    checkVal("rst_rf_wdata", 64'(rf_wdata),    64'd0);
    checkVal("rst_done",     64'(init_done),   64'd0);
    checkVal("rst_pending",  64'(pending_cnt), 64'd0);
    checkVal("rst_ready",    64'(wb_ready),    64'd0);
    releaseReset();

    // Zero-fill: 31 write cycles, then the file reads all zero
    idle(34, 5'd3, 5'd31);
    for (int r = 1; r < NUM_REGS; r++) checkVal("init_mem", 64'(rfMem[r]), 64'd0);

    // Two back-to-back writes
    step(1'b1, 5'd1, 32'd3, 5'd1, 5'd3);
    step(1'b1, 5'd3, 32'd1, 5'd1, 5'd3);
    idle(3, 5'd1, 5'd3);
    checkVal("mem_r1", 64'(rfMem[1]), 64'd3);
    checkVal("mem_r3", 64'(rfMem[3]), 64'd1);

    // Zero register request: accepted, discarded
    step(1'b1, 5'd0, 32'd45, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);

    // Sustained valid with six distinct requests
    idx    = 0;
    budget = 0;
    while (idx < DEPTH + 2 && budget < 40) begin
      bit rdy;
      rdy = mReady();
      step(1'b1, AW'(4 + idx), DW'(idx - 9), AW'(4 + idx), 5'd9);
      if (rdy) idx++;
      budget++;
    end
    checkVal("bp_all_accepted", 64'(idx), 64'(DEPTH + 2));
    idle(3, 5'd4, 5'd9);

    // Newest pending write to the same register wins
    step(1'b1, 5'd4, 32'hFFFF_FFF7, 5'd4, 5'd0);
    step(1'b1, 5'd4, 32'd45, 5'd4, 5'd0);
    checkVal("fwd_prio_data", 64'(fwd_data1), 64'd45);
    idle(4, 5'd4, 5'd0);
    checkVal("mem_r4", 64'(rfMem[4]), 64'd45);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    // Reset with work in flight: nothing pending may reach the file
    step(1'b1, 5'd10, 32'hA5A5_0001, 5'd10, 5'd11);
    step(1'b1, 5'd11, 32'hA5A5_0002, 5'd10, 5'd11);
    wb_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkVal("mid_rst_rf_we",   64'(rf_we),       64'd0);
    checkVal("mid_rst_pending", 64'(pending_cnt), 64'd0);
    checkVal("mid_rst_ready",   64'(wb_ready),    64'd0);
    checkVal("mid_rst_hit1",    64'(fwd_hit1),    64'd0);
    checkVal("mid_rst_done",    64'(init_done),   64'd0);
    modelReset();
    @(negedge clk);
    releaseReset();
    step(1'b0, '0, '0, 5'd10, 5'd11);
    checkVal("reinit_first_addr", 64'(rf_waddr), 64'd1);
    idle(34, 5'd10, 5'd11);

    // More random traffic after the restart, then drain and compare the file
    for (int n = 0; n < 150; n++) begin
      step($urandom_range(0, 1) != 0, AW'($urandom_range(0, 31)), $urandom,
           AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    end
    idle(DEPTH + 3, 5'd0, 5'd0);
    for (int r = 1; r < NUM_REGS; r++) checkVal("final_mem", 64'(rfMem[r]), 64'(mMem[r]));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_writeback_ctrl.md
Name: regfile_writeback_ctrl

Overview:
Initiator side of the register-file write port. It accepts writeback requests from the pipeline through a valid/ready handshake and buffers them in a small FIFO. It drains one request per cycle onto the RegisterFile write port (ReadWriteEn/WriteAddress/WriteData) and forwards pending data to readers. After reset it zero-fills registers 1..31, because the RegisterFile itself has no reset.

Parameters:
DEPTH, 4, writeback buffer entries (power of 2, >=2)
DATA_W, 32, register data width
ADDR_W, 5, register address width (32 registers)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
wb_valid  in  1  writeback request valid
wb_ready  out  1  controller can accept a request
wb_addr  in  ADDR_W  destination register
wb_data  in  DATA_W  writeback value
rf_we  out  1  drives RegisterFile ReadWriteEn
rf_waddr  out  ADDR_W  drives RegisterFile WriteAddress
rf_wdata  out  DATA_W  drives RegisterFile WriteData
fwd_addr1  in  ADDR_W  lookup address, read port 1
fwd_addr2  in  ADDR_W  lookup address, read port 2
fwd_hit1  out  1  pending write matches fwd_addr1
fwd_data1  out  DATA_W  forwarded value for fwd_addr1
fwd_hit2  out  1  pending write matches fwd_addr2
fwd_data2  out  DATA_W  forwarded value for fwd_addr2
init_done  out  1  zero-fill complete
pending_cnt  out  $clog2(DEPTH)+1  occupied buffer entries

Behaviour:
- Reset (async, while rst=1) sets: state=INIT, init_ptr=1, buffer empty, rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, pending_cnt=0. wb_ready=0 and fwd_hit*=0 during reset.
- rf_we, rf_waddr and rf_wdata are registered.
- INIT state: on each edge, rf_we<=1, rf_waddr<=init_ptr, rf_wdata<=0, init_ptr++.
  - The edge that presents address 31 also sets state<=RUN and init_done<=1.
  - Addresses 1..31 are presented on 31 consecutive edges after reset release.
  - Address 0 is never written.
- RUN state:
  - wb_ready = (state==RUN) && (pending_cnt<DEPTH), combinational.
  - A push occurs when wb_valid && wb_ready at an edge.
  - A request with wb_addr==0 is accepted (handshake completes) but discarded: no push, no rf write.
  - On each edge with a non-empty buffer, the head is popped: rf_we<=1, rf_waddr<=head.addr, rf_wdata<=head.data. With an empty buffer, rf_we<=0 and rf_waddr/rf_wdata hold.
  - Latency: a request pushed at edge N into an empty buffer appears on rf_* after edge N+1. Sustained throughput is 1 request/cycle.
  - Push and pop may occur at the same edge. When full, wb_ready=0 even if a pop occurs that edge (no fall-through).
  - Ordering is strictly FIFO. Writes to the same register land in issue order.
- Forwarding (combinational, per port):
  - Candidates are all valid buffer entries plus the current rf_* output when rf_we=1. That value is not yet in the RegisterFile until the next edge.
  - Priority is newest first: buffer tail down to head, then the rf_* output.
  - fwd_addr==0 never hits. In INIT, hits are suppressed.
  - On a miss, fwd_data=0.
- Reset asserted mid-operation: pending entries are dropped (not written), and INIT restarts from register 1.
- pending_cnt tracks buffer occupancy only. It excludes the entry currently on rf_*.
- Pointers wrap modulo DEPTH. A separate full/empty count disambiguates ptr equality.

Decomposition:
- Package regfile_pkg:
  - ADDR_W, DATA_W, NUM_REGS=32, ZERO_REG=0
  - wb_state_t enum {INIT, RUN}
  - wb_entry_t struct {addr, data}
- Sub-module wb_fifo: a DEPTH-entry synchronous FIFO that exposes all entries and their valid bits for the forwarding search. The top level holds the FSM, the init counter, the rf_* output registers and the two forwarding muxes.

Test Plan:
- Init fill: release rst and hold wb_valid=0. Required: rf_we=1 for 31 consecutive cycles with rf_waddr=1..31 and rf_wdata=0, then init_done=1 and rf_we=0. Then read RegisterFile R1..R31 and expect 0.
- Single write: push (addr=1, data=3), then (addr=3, data=1). Required: rf_* shows 1/3 then 3/1 on consecutive cycles. RegisterFile later reads R1=3, R3=1.
- Zero register: push (addr=0, data=45). Required: handshake completes, rf_we stays 0, pending_cnt=0, fwd_hit=0 with fwd_addr=0.
- Backpressure: hold wb_valid=1 with DEPTH+2 distinct requests (addr 4..9, data=-9..-4). Required: wb_ready drops only when pending_cnt=4, no request is lost, and rf_waddr sequence is 4..9.
- Forwarding priority: push (addr=4, data=-9), then (addr=4, data=45) back-to-back, with fwd_addr1=4. Required: fwd_hit1=1 and fwd_data1=45 while either write is pending. After both drain, fwd_hit1=0 and the RegisterFile reads R4=45.
- Reset mid-stream: assert rst with 3 entries pending. Required: rf_we=0 immediately, and no pending entry is ever written. INIT restarts at rf_waddr=1.
